// File: rtl/multicycle_bus_sequencer_if.sv
// multicycle_bus_sequencer_if: shared variable-latency memory bus, one transaction outstanding
interface multicycle_bus_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_ack;
  logic [31:0] bus_read_data;
  modport master (
    output bus_req, bus_we, bus_address, bus_write_data, bus_byte_enable,
    input  bus_ack, bus_read_data
  );
  modport slave (
    input  bus_req, bus_we, bus_address, bus_write_data, bus_byte_enable,
    output bus_ack, bus_read_data
  );
endinterface

// File: rtl/multicycle_bus_sequencer.sv
// multicycle_bus_sequencer: time-multiplexes fetch and load/store over one bus, commits once per instruction
module multicycle_bus_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_INST     = 32'h00000013
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [31:0]                        pc,
  input  logic [31:0]                        data_mem_address,
  input  logic [31:0]                        data_mem_write_data,
  input  logic [3:0]                         data_byte_enable,
  input  logic                               is_load,
  input  logic                               is_store,
  input  logic                               reg_write_request,
  multicycle_bus_sequencer_if.master         bus,
  output logic [31:0]                        inst,
  output logic [31:0]                        data_mem_read_data,
  output logic                               pc_write_enable,
  output logic                               regfile_write_enable,
  output logic [31:0]                        retired_count,
  output logic                               fault
);
  typedef enum logic [2:0] {IDLE, FETCH, EXECUTE, MEM, WRITEBACK, FAULT} state_t;
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d, rdata_q, rdata_d, retired_q, retired_d;
  logic [15:0] cnt_q, cnt_d;
  logic        expired;
  assign expired = cnt_q == LAST_WAIT;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      inst_q    <= RESET_INST;
      rdata_q   <= '0;
      retired_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
      retired_q <= retired_d;
      cnt_q     <= cnt_d;
    end
  // counter idles at zero outside FETCH/MEM, so it is already clear on entry
  always_comb begin
    state_d              = state_q;
    inst_d               = inst_q;
    rdata_d              = rdata_q;
    retired_d            = retired_q;
    cnt_d                = '0;
    bus.bus_req          = 1'b0;
    bus.bus_we           = 1'b0;
    bus.bus_address      = '0;
    bus.bus_write_data   = '0;
    bus.bus_byte_enable  = '0;
    pc_write_enable      = 1'b0;
    regfile_write_enable = 1'b0;
    case (state_q)
      IDLE: state_d = enable ? FETCH : IDLE;
      FETCH: begin
        bus.bus_req         = 1'b1;
        bus.bus_address     = pc;
        bus.bus_byte_enable = 4'hF;
        cnt_d               = bus.bus_ack ? '0 : cnt_q + 16'd1;
        inst_d              = bus.bus_ack ? bus.bus_read_data : inst_q;
        state_d             = bus.bus_ack ? EXECUTE : (expired ? FAULT : FETCH);
      end
      EXECUTE: begin
        pc_write_enable      = ~(is_load | is_store);
        regfile_write_enable = ~(is_load | is_store) & reg_write_request;
        retired_d            = (is_load | is_store) ? retired_q : retired_q + 32'd1;
        state_d              = (is_load | is_store) ? MEM : (enable ? FETCH : IDLE);
      end
      MEM: begin
        bus.bus_req         = 1'b1;
        bus.bus_we          = is_store;
        bus.bus_address     = data_mem_address;
        bus.bus_write_data  = data_mem_write_data;
        bus.bus_byte_enable = is_store ? data_byte_enable : 4'hF;
        cnt_d               = bus.bus_ack ? '0 : cnt_q + 16'd1;
        rdata_d             = (bus.bus_ack && is_load) ? bus.bus_read_data : rdata_q;
        state_d             = bus.bus_ack ? WRITEBACK : (expired ? FAULT : MEM);
      end
      WRITEBACK: begin
        pc_write_enable      = 1'b1;
        regfile_write_enable = reg_write_request & ~is_store;
        retired_d            = retired_q + 32'd1;
        state_d              = enable ? FETCH : IDLE;
      end
      default: state_d = FAULT;
    endcase
  end
  assign inst               = inst_q;
  assign data_mem_read_data = rdata_q;
  assign retired_count      = retired_q;
  assign fault              = state_q == FAULT;
endmodule
